// File: rtl/uart_cmd_decoder_if.sv
// Byte stream from the UART receiver into the command decoder.
// The receiver side is the master; the decoder listens as the slave.
interface uart_cmd_decoder_if;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_frame_error;

  modport master (
    output i_data,
    output i_data_valid,
    output i_frame_error
  );

  modport slave (
    input i_data,
    input i_data_valid,
    input i_frame_error
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Snake-game key decoder: WASD, P, R and ANSI arrow sequences.
// Blocks 180-degree turns; all outputs registered, events one cycle wide.
module uart_cmd_decoder #(
  parameter int ESC_TIMEOUT = 50000,
  parameter int TIMEOUT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_cmd_decoder_if.slave  rx,
  output logic [1:0]         o_dir,
  output logic               o_dir_valid,
  output logic               o_pause_toggle,
  output logic               o_restart,
  output logic               o_unknown,
  output logic [7:0]         o_frame_err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    CSI
  } state_e;

  localparam logic [TIMEOUT_W-1:0] TMAX =
    TIMEOUT_W'(ESC_TIMEOUT - 1);

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_RIGHT = 2'b01;
  localparam logic [1:0] D_DOWN  = 2'b10;
  localparam logic [1:0] D_LEFT  = 2'b11;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [1:0]           dir_q, dir_d;
  logic                 dv_q, dv_d;
  logic                 pause_q, pause_d;
  logic                 rst_q, rst_d;
  logic                 unk_q, unk_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 fe_q;

  logic       fe_rise;
  logic       req_v;
  logic [1:0] req_dir;
  logic       restart;
  logic [7:0] key;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= D_RIGHT;
      dv_q    <= 1'b0;
      pause_q <= 1'b0;
      rst_q   <= 1'b0;
      unk_q   <= 1'b0;
      cnt_q   <= 8'd0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      dv_q    <= dv_d;
      pause_q <= pause_d;
      rst_q   <= rst_d;
      unk_q   <= unk_d;
      cnt_q   <= cnt_d;
      fe_q    <= rx.i_frame_error;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = (state_q == IDLE) ? '0 : timer_q + 1'b1;
    dir_d   = dir_q;
    dv_d    = 1'b0;
    pause_d = 1'b0;
    rst_d   = 1'b0;
    unk_d   = 1'b0;
    cnt_d   = cnt_q;
    req_v   = 1'b0;
    req_dir = dir_q;
    restart = 1'b0;
    fe_rise = rx.i_frame_error & ~fe_q;

    // Fold upper-case letters onto lower case
    key = rx.i_data;
    if (rx.i_data >= 8'h41 && rx.i_data <= 8'h5A)
      key = rx.i_data | 8'h20;

    if (fe_rise && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;

    if (rx.i_data_valid) begin
      if (state_q == CSI) begin
        state_d = IDLE;
        req_v   = 1'b1;
        case (rx.i_data)
          8'h41:   req_dir = D_UP;
          8'h42:   req_dir = D_DOWN;
          8'h43:   req_dir = D_RIGHT;
          8'h44:   req_dir = D_LEFT;
          default: begin
            req_v = 1'b0;
            unk_d = 1'b1;
          end
        endcase
      end else if (state_q == ESC &&
                   rx.i_data == 8'h5B) begin
        state_d = CSI;
        timer_d = '0;
      end else begin
        state_d = IDLE;
        case (key)
          8'h77: begin req_v = 1'b1; req_dir = D_UP;    end
          8'h64: begin req_v = 1'b1; req_dir = D_RIGHT; end
          8'h73: begin req_v = 1'b1; req_dir = D_DOWN;  end
          8'h61: begin req_v = 1'b1; req_dir = D_LEFT;  end
          8'h70: pause_d = 1'b1;
          8'h72: restart = 1'b1;
          8'h1B: begin
            state_d = ESC;
            timer_d = '0;
          end
          default: unk_d = 1'b1;
        endcase
      end
    end else if (fe_rise) begin
      state_d = IDLE;
    end else if (state_q != IDLE && timer_q == TMAX) begin
      state_d = IDLE;
    end

    if (restart) begin
      rst_d = 1'b1;
      if (dir_q != D_RIGHT) begin
        dir_d = D_RIGHT;
        dv_d  = 1'b1;
      end
    end else if (req_v && req_dir != dir_q &&
                 req_dir != (dir_q ^ 2'b10)) begin
      dir_d = req_dir;
      dv_d  = 1'b1;
    end
  end

  assign o_dir           = dir_q;
  assign o_dir_valid     = dv_q;
  assign o_pause_toggle  = pause_q;
  assign o_restart       = rst_q;
  assign o_unknown       = unk_q;
  assign o_frame_err_cnt = cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed key sequences,
// a keystroke-level reference model and literal spot checks.
module tb_uart_cmd_decoder;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] o_dir;
  logic       o_dir_valid;
  logic       o_pause_toggle;
  logic       o_restart;
  logic       o_unknown;
  logic [7:0] o_frame_err_cnt;

  always #5 clk = ~clk;

  uart_cmd_decoder_if rx ();

  uart_cmd_decoder #(
    .ESC_TIMEOUT(T),
    .TIMEOUT_W  (5)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .rx             (rx),
    .o_dir          (o_dir),
    .o_dir_valid    (o_dir_valid),
    .o_pause_toggle (o_pause_toggle),
    .o_restart      (o_restart),
    .o_unknown      (o_unknown),
    .o_frame_err_cnt(o_frame_err_cnt)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Reference model: pending escape prefix kept as a string
  string pend = "";
  int    age  = 0;
  bit [1:0] m_dir = 2'd1;
  int    m_cnt = 0;
  bit    m_fe  = 1'b0;
  bit    e_dv, e_pa, e_rs, e_un;

  function automatic void want(bit [1:0] r);
    if (r != m_dir && r != (m_dir ^ 2'b10)) begin
      m_dir = r;
      e_dv  = 1'b1;
    end
  endfunction

  function automatic void plain(byte b);
    byte c;
    c = b;
    if (b >= "A" && b <= "Z") c = b + 8'd32;
    pend = "";
    case (c)
      "w": want(2'd0);
      "d": want(2'd1);
      "s": want(2'd2);
      "a": want(2'd3);
      "p": e_pa = 1'b1;
      "r": begin
        e_rs = 1'b1;
        if (m_dir != 2'd1) begin
          m_dir = 2'd1;
          e_dv  = 1'b1;
        end
      end
      8'h1B: begin
        pend = "E";
        age  = 0;
      end
      default: e_un = 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    bit rise;
    e_dv = 0; e_pa = 0; e_rs = 0; e_un = 0;
    if (rst) begin
      pend = ""; age = 0; m_dir = 2'd1;
      m_cnt = 0; m_fe = 1'b0;
    end else begin
      rise = rx.i_frame_error && !m_fe;
      m_fe = rx.i_frame_error;
      if (rise && m_cnt < 255) m_cnt++;
      if (rx.i_data_valid) begin
        if (pend == "E[") begin
          pend = "";
          if (rx.i_data >= "A" && rx.i_data <= "D") begin
            case (rx.i_data)
              "A": want(2'd0);
              "B": want(2'd2);
              "C": want(2'd1);
              default: want(2'd3);
            endcase
          end else e_un = 1'b1;
        end else if (pend == "E" && rx.i_data == "[") begin
          pend = "E[";
          age  = 0;
        end else plain(rx.i_data);
      end else if (rise) begin
        pend = "";
      end else if (pend != "") begin
        if (age == T - 1) pend = "";
        else age++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tot++;
      if (o_dir == m_dir && o_dir_valid == e_dv &&
          o_pause_toggle == e_pa && o_restart == e_rs &&
          o_unknown == e_un && o_frame_err_cnt == m_cnt)
        n_pass++;
      else
        $display("FAIL cycle t=%0t dut dir=%0d dv=%0d pa=%0d rs=%0d un=%0d cnt=%0d want %0d %0d %0d %0d %0d %0d",
                 $time, o_dir, o_dir_valid, o_pause_toggle,
                 o_restart, o_unknown, o_frame_err_cnt,
                 m_dir, e_dv, e_pa, e_rs, e_un, m_cnt);
    end
  end

  task automatic send(byte b);
    @(negedge clk);
    rx.i_data       = b;
    rx.i_data_valid = 1'b1;
    @(negedge clk);
    rx.i_data_valid = 1'b0;
    rx.i_data       = 8'h00;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx.i_data        = 8'h00;
    rx.i_data_valid  = 1'b0;
    rx.i_frame_error = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_dir", o_dir, 1);
    chk("rst_cnt", o_frame_err_cnt, 0);
    rst = 1'b0;
    idle(2);

    send("w");
    chk("w_dir", o_dir, 0);
    chk("w_dv", o_dir_valid, 1);
    send("s");
    chk("s_dv", o_dir_valid, 0);
    chk("s_dir", o_dir, 0);

    send(8'h1B); idle(10);
    send(8'h5B); idle(10);
    send(8'h44);
    chk("arrow_dir", o_dir, 3);
    chk("arrow_dv", o_dir_valid, 1);
    chk("arrow_unk", o_unknown, 0);
    send("w");

    send(8'h1B); idle(T);
    send("A");
    chk("tmo_dir", o_dir, 3);
    chk("tmo_unk", o_unknown, 0);

    send(8'h1B); idle(T - 2);
    send("["); send("B");
    chk("edge_dir", o_dir, 2);
    chk("edge_unk", o_unknown, 0);
    send(8'h1B); idle(T - 1);
    send("[");
    chk("late_unk", o_unknown, 1);

    send(8'h1B); send("p");
    chk("escp_pause", o_pause_toggle, 1);
    chk("escp_unk", o_unknown, 0);
    send("C");
    chk("idle_C_unk", o_unknown, 1);

    send(8'h1B);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) rx.i_frame_error = 1'b1;
      @(negedge clk) rx.i_frame_error = 1'b0;
      if (i == 0) chk("fe_cnt1", o_frame_err_cnt, 1);
    end
    chk("fe_sat", o_frame_err_cnt, 255);
    send("[");
    chk("fe_abort_unk", o_unknown, 1);

    @(negedge clk);
    rx.i_frame_error = 1'b1;
    rx.i_data_valid  = 1'b1;
    rx.i_data        = 8'h1B;
    @(negedge clk);
    rx.i_frame_error = 1'b0;
    rx.i_data_valid  = 1'b0;
    send("["); send("C");
    chk("fe_byte_dir", o_dir, 1);
    chk("fe_hold", o_frame_err_cnt, 255);

    send("w");
    send("R");
    chk("R_rst", o_restart, 1);
    chk("R_dv", o_dir_valid, 1);
    chk("R_dir", o_dir, 1);
    send("r");
    chk("r_rst", o_restart, 1);
    chk("r_dv", o_dir_valid, 0);

    send("s");
    send(8'h1B); send(8'h5B);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst2_dir", o_dir, 1);
    chk("rst2_cnt", o_frame_err_cnt, 0);
    send("C");
    chk("rst2_unk", o_unknown, 1);
    chk("rst2_dir_after", o_dir, 1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
